// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera frame-capture block.
package cam_pkg;

    localparam int unsigned IMG_W_DEF = 640;
    localparam int unsigned IMG_H_DEF = 480;
    localparam int unsigned WIN_W_DEF = 250;
    localparam int unsigned WIN_H_DEF = 250;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PIX_W  = 16;

    // Luma weights scaled by 256
    localparam int unsigned GRAY_COEF_R = 77;
    localparam int unsigned GRAY_COEF_G = 150;
    localparam int unsigned GRAY_COEF_B = 29;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [PIX_W-1:0]  data;
    } pix_wr_t;

endpackage

// File: rtl/rgb565_to_gray.sv
// One registered stage converting an RGB565 write into an 8-bit luma write.
// Built only when CAP_GRAYSCALE_EN is defined.
`ifdef CAP_GRAYSCALE_EN
module rgb565_to_gray
    import cam_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  pix_wr_t in_wr,
    output logic    out_valid,
    output pix_wr_t out_wr
);

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;

    // Expand channels to 8 bits by replicating MSBs; weighted sum fits in 16 bits
    always_comb begin
        r8  = {in_wr.data[15:11], in_wr.data[15:13]};
        g8  = {in_wr.data[10:5],  in_wr.data[10:9]};
        b8  = {in_wr.data[4:0],   in_wr.data[4:2]};
        sum = 16'(GRAY_COEF_R) * 16'(r8)
            + 16'(GRAY_COEF_G) * 16'(g8)
            + 16'(GRAY_COEF_B) * 16'(b8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_wr    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_wr.row  <= in_wr.row;
                out_wr.col  <= in_wr.col;
                out_wr.data <= sum >> 8;
            end
        end
    end

endmodule
`endif

// File: rtl/cam_frame_capture.sv
// Captures a WIN_W x WIN_H crop of an 8-bit-bus RGB565 camera stream into a frame buffer.
// Define CAP_GRAYSCALE_EN to write 8-bit luma instead of raw RGB565 (one extra cycle latency).
module cam_frame_capture
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF,
    parameter int unsigned WIN_H = WIN_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_data,
    input  logic              freeze,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_row,
    output logic [ADDR_W-1:0] wr_col,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              frozen,
    output logic              err_overrun
);

    // Counters hold one value past the image edge so overruns stay visible
    localparam int unsigned X_W = $clog2(IMG_W + 1);
    localparam int unsigned Y_W = $clog2(IMG_H + 1);

    cap_state_e state_q;
    cap_state_e state_d;

    logic              vsync_q;
    logic              href_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic              phase_q;
    logic [BYTE_W-1:0] hi_q;

    logic vsync_rise;
    logic vsync_fall;
    logic line_end;
    logic byte_ok;
    logic pix_done;
    logic x_over;
    logic y_over;
    logic in_win;
    logic wr_req;
    logic frame_done_d;

    logic    s1_valid;
    pix_wr_t s1_wr;

    // A vsync rise with href still high closes the line; that cycle's byte is dropped
    always_comb begin
        vsync_rise = cam_vsync & ~vsync_q;
        vsync_fall = ~cam_vsync & vsync_q;
        line_end   = (href_q & ~cam_href) | (vsync_rise & cam_href);
        byte_ok    = cam_href & ~vsync_rise;
        pix_done   = byte_ok & phase_q;
        x_over     = (x_q >= X_W'(IMG_W));
        y_over     = (y_q >= Y_W'(IMG_H));
        in_win     = (x_q < X_W'(WIN_W)) && (y_q < Y_W'(WIN_H));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            frozen  <= 1'b0;
        end else begin
            state_q <= state_d;
            frozen  <= (state_d == FROZEN);
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_req       = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (vsync_fall) state_d = CAPTURE;
            end
            CAPTURE: begin
                wr_req       = pix_done & in_win & ~x_over & ~y_over;
                frame_done_d = vsync_rise & ((y_q != '0) | (line_end & (x_q != '0)));
                if (vsync_rise && freeze) state_d = FROZEN;
            end
            FROZEN: begin
                if (vsync_rise && !freeze) state_d = CAPTURE;
            end
            default: state_d = SYNC;
        endcase
    end

    // Sync edge detection, byte pairing and pixel/line counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            err_overrun <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;

            if (!byte_ok) phase_q <= 1'b0;
            else          phase_q <= ~phase_q;

            if (byte_ok && !phase_q) hi_q <= cam_data;

            if (line_end || vsync_rise)  x_q <= '0;
            else if (pix_done && !x_over) x_q <= x_q + X_W'(1);

            if (vsync_rise)                              y_q <= '0;
            else if (line_end && (x_q != '0) && !y_over) y_q <= y_q + Y_W'(1);

            if (byte_ok && (x_over || y_over)) err_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_wr      <= '0;
            frame_done <= 1'b0;
        end else begin
            s1_valid   <= wr_req;
            frame_done <= frame_done_d;
            if (wr_req) begin
                s1_wr.row  <= ADDR_W'(y_q);
                s1_wr.col  <= ADDR_W'(x_q);
                s1_wr.data <= {hi_q, cam_data};
            end
        end
    end

`ifdef CAP_GRAYSCALE_EN
    logic    g_valid;
    pix_wr_t g_wr;

    rgb565_to_gray u_gray (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_wr     (s1_wr),
        .out_valid (g_valid),
        .out_wr    (g_wr)
    );

    assign wr_en   = g_valid;
    assign wr_row  = g_wr.row;
    assign wr_col  = g_wr.col;
    assign wr_data = g_wr.data;
`else
    assign wr_en   = s1_valid;
    assign wr_row  = s1_wr.row;
    assign wr_col  = s1_wr.col;
    assign wr_data = s1_wr.data;
`endif

endmodule

// File: tb/tb_cam_frame_capture.sv
// Scoreboard bench for cam_frame_capture on a reduced image geometry.
module tb_cam_frame_capture;
    import cam_pkg::*;

    localparam int unsigned TW = 40;
    localparam int unsigned TH = 30;
    localparam int unsigned WW = 25;
    localparam int unsigned WH = 20;
`ifdef CAP_GRAYSCALE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        freeze;
    logic        wr_en;
    logic [7:0]  wr_row;
    logic [7:0]  wr_col;
    logic [15:0] wr_data;
    logic        frame_done;
    logic        frozen;
    logic        err_overrun;

    cam_frame_capture #(
        .IMG_W (TW),
        .IMG_H (TH),
        .WIN_W (WW),
        .WIN_H (WH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .freeze      (freeze),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .frozen      (frozen),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_pass   = 0;
    int n_checks = 0;
    int wr_count = 0;
    int fd_count = 0;
    logic [7:0] last_row = '0;
    logic [7:0] last_col = '0;

    cap_state_e st_m;
    int         x_m;
    int         y_m;
    bit         ph_m;
    logic [7:0] hi_m;
    bit         err_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_data(input logic [15:0] p);
`ifdef CAP_GRAYSCALE_EN
        int r8;
        int g8;
        int b8;
        r8 = int'({p[15:11], p[15:13]});
        g8 = int'({p[10:5], p[10:9]});
        b8 = int'({p[4:0], p[4:2]});
        return 16'((77 * r8 + 150 * g8 + 29 * b8) / 256);
`else
        return p;
`endif
    endfunction

    // Output monitor: pops scoreboard entries on their due cycle
    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (wr_en) begin
            wr_count++;
            last_row = wr_row;
            last_col = wr_col;
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            check_eq("write_missed_cycle", cyc, mon_e.due);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check_eq("wr_en", wr_en, 1'b1);
            check_eq("wr_row", wr_row, mon_e.row);
            check_eq("wr_col", wr_col, mon_e.col);
            check_eq("wr_data", wr_data, mon_e.data);
        end else if (wr_en) begin
            check_eq("spurious_wr_en", wr_en, 1'b0);
        end
    end

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (x_m >= int'(TW) || y_m >= int'(TH)) err_m = 1'b1;
        if (!ph_m) begin
            hi_m = b;
        end else begin
            if (st_m == CAPTURE && x_m < int'(WW) && y_m < int'(WH))
                sb.push_back('{due: cyc + LAT, row: 8'(y_m), col: 8'(x_m), data: exp_data({hi_m, b})});
            if (x_m < int'(TW)) x_m++;
        end
        ph_m = ~ph_m;
        drive(1'b0, 1'b1, b);
    endtask

    task automatic end_line();
        drive(1'b0, 1'b0, 8'h00);
        if (x_m > 0 && y_m < int'(TH)) y_m++;
        x_m  = 0;
        ph_m = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
        end_line();
    endtask

    task automatic full_frame();
        for (int r = 0; r < int'(TH); r++) send_line(2 * int'(TW));
    endtask

    // Frame boundary: vsync high for four cycles, then low
    task automatic vsync_frame_end(input bit with_href);
        int fd0;
        int exp_fd;
        fd0 = fd_count;
        if (with_href) begin
            if (x_m > 0 && y_m < int'(TH)) y_m++;
            x_m  = 0;
            ph_m = 1'b0;
        end
        exp_fd = (st_m == CAPTURE && y_m > 0) ? 1 : 0;
        case (st_m)
            CAPTURE: if (freeze)  st_m = FROZEN;
            FROZEN:  if (!freeze) st_m = CAPTURE;
            default: ;
        endcase
        y_m = 0;
        x_m = 0;
        drive(1'b1, with_href, 8'h5A);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        check_eq("frame_done_pulses", fd_count - fd0, exp_fd);
        check_eq("frozen", frozen, (st_m == FROZEN));
        drive(1'b0, 1'b0, 8'h00);
        if (st_m == SYNC) st_m = CAPTURE;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        rst   = 1'b0;
        st_m  = SYNC;
        x_m   = 0;
        y_m   = 0;
        ph_m  = 1'b0;
        err_m = 1'b0;
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_row", wr_row, 8'h00);
        check_eq("rst_wr_col", wr_col, 8'h00);
        check_eq("rst_wr_data", wr_data, 16'h0000);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_frozen", frozen, 1'b0);
        check_eq("rst_err_overrun", err_overrun, 1'b0);
    endtask

    initial begin
        int w0;
        rst       = 1'b1;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        freeze    = 1'b0;
        do_reset();

        // Lines before the first vsync fall are not captured
        w0 = wr_count;
        send_line(6);
        check_eq("sync_no_writes", wr_count - w0, 0);
        vsync_frame_end(1'b0);

        // Basic pixel assembly
        send_byte(8'hF8);
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'hE0);
        end_line();
        check_eq("first_line_last_col", last_col, 8'd1);
        vsync_frame_end(1'b0);

        // Full frame, cropped window
        w0 = wr_count;
        full_frame();
        vsync_frame_end(1'b0);
        check_eq("frame_writes", wr_count - w0, WW * WH);
        check_eq("frame_last_row", last_row, 8'(WH - 1));
        check_eq("frame_last_col", last_col, 8'(WW - 1));
        check_eq("err_after_full_frame", err_overrun, err_m);

        // Freeze raised mid-frame: current frame still fully written
        w0 = wr_count;
        for (int r = 0; r < int'(TH); r++) begin
            if (r == int'(TH) / 2) freeze = 1'b1;
            send_line(2 * int'(TW));
        end
        vsync_frame_end(1'b0);
        check_eq("freeze_frame_writes", wr_count - w0, WW * WH);

        // Frozen frame; dropping freeze mid-frame has no effect until vsync
        w0 = wr_count;
        for (int r = 0; r < int'(TH); r++) begin
            if (r == int'(TH) / 2) begin
                freeze = 1'b0;
                check_eq("frozen_mid_frame", frozen, 1'b1);
            end
            send_line(2 * int'(TW));
        end
        vsync_frame_end(1'b0);
        check_eq("frozen_frame_writes", wr_count - w0, 0);

        // Writes resume; odd trailing byte dropped
        w0 = wr_count;
        for (int r = 0; r < 3; r++) send_line(2 * int'(TW));
        send_line(7);
        vsync_frame_end(1'b0);
        check_eq("resume_writes", wr_count - w0, 3 * WW + 3);

        // Line overrun: 2*IMG_W+1 bytes
        check_eq("err_before_overrun", err_overrun, 1'b0);
        for (int i = 0; i < 2 * int'(TW); i++) send_byte(8'($urandom_range(0, 255)));
        check_eq("err_at_img_w", err_overrun, err_m);
        send_byte(8'hA5);
        check_eq("err_after_extra_byte", err_overrun, err_m);
        end_line();
        vsync_frame_end(1'b0);
        check_eq("err_sticky", err_overrun, 1'b1);

        // vsync rises while href is still high
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
        vsync_frame_end(1'b1);

        // Reset after first byte of a pixel
        send_byte(8'h12);
        do_reset();
        w0 = wr_count;
        send_line(2 * int'(TW));
        check_eq("post_reset_no_writes", wr_count - w0, 0);
        vsync_frame_end(1'b0);
        w0 = wr_count;
        send_line(8);
        vsync_frame_end(1'b0);
        check_eq("post_reset_resume", wr_count - w0, 4);

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
        check_eq("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
